prefetch_buffer: RTL and testbench
==================================

# prefetch_buffer

Consumer side of the stride prefetcher: it takes the prefetch address and prefetch enable that the prediction table produces, and turns them into L2 line reads. Incoming requests are de-duplicated and queued, then issued on the L2 read port only when no demand miss is using it. Returned lines are held in a small fully-associative buffer, which the data cache miss path probes before going to L2.

## Interface
- DEPTH, 4, request FIFO entries (power of two, ≥2)
- LINES, 4, prefetch buffer entries (power of two, ≥2)
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- pf_addr  input  32  prefetch byte address; line address = pf_addr[31:5]
- pf_en  input  1  prefetch request valid this cycle
- demand_busy  input  1  demand miss owns the L2 port; no new issue while high
- mem_read  output  1  L2 read request, held until mem_resp
- mem_addr  output  32  {line, 5'b0} of request in flight; 0 when idle
- mem_rdata  input  256  L2 line data, valid with mem_resp
- mem_resp  input  1  L2 read complete (1-cycle pulse)
- lookup_addr  input  32  demand miss address from cache
- lookup_valid  input  1  demand probe valid
- lookup_hit  output  1  combinational: valid buffer entry matches lookup_addr[31:5]
- lookup_data  output  256  data of matching entry; 0 on miss
- req_full  output  1  FIFO occupancy == DEPTH

## Operation
- Request FIFO: circular, DEPTH entries of 27-bit line address; head/tail pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
- Push on pf_en only if FIFO not full AND line not already in any FIFO entry (head included) AND not in any valid buffer entry; otherwise request silently dropped.
- Full rule: push rejected when count==DEPTH even if a pop occurs the same cycle.
- FSM states IDLE, ISSUE, WRITE:
  - IDLE -> ISSUE when count≠0 and demand_busy==0.
  - ISSUE: mem_read=1, mem_addr={head line,5'b0}; on mem_resp latch mem_rdata and go to WRITE. demand_busy changes during ISSUE are ignored.
  - WRITE: write latched line and tag into victim entry, set its valid bit, pop FIFO head, advance victim pointer (round-robin modulo LINES), go to IDLE.
- Head line remains in FIFO through ISSUE and WRITE, so a duplicate pf_en for the in-flight line is dropped.
- Lookup: if lookup_valid and lookup_hit, matching entry's valid cleared at next edge (line is consumed by cache fill).
- Simultaneous WRITE and consume on the same entry: write wins, entry ends valid with new line.
- Lookup for the line being written in WRITE misses (no bypass).
- Reset, including mid-ISSUE: FSM to IDLE, FIFO emptied, all valid bits cleared, victim pointer 0; any later mem_resp while IDLE is ignored.

## Timing
- Reset values: mem_read=0, mem_addr=0, req_full=0, lookup_hit=0, lookup_data=0.
- pf_en accepted at edge t: count updated after t; earliest mem_read high cycle t+1 (if IDLE, demand_busy low).
- mem_resp in cycle k: WRITE in cycle k+1; entry valid and lookup_hit possible from cycle k+2; next mem_read earliest k+3.
- Minimum 3 cycles per prefetch (1 ISSUE cycle + WRITE + IDLE).
- lookup_hit and lookup_data are purely combinational from lookup_addr and registered buffer state.

## Test plan
- Reset, pf_en=1 with pf_addr=0x1000_0044, demand_busy=0 -> next cycle mem_read=1, mem_addr=0x1000_0040; mem_resp with data D -> two cycles later, lookup 0x1000_0050 gives hit=1, data=D; after consume, hit=0.
- Same line requested twice (0x200, then 0x21C) while the first is in ISSUE -> exactly one L2 read.
- Five distinct lines pushed back-to-back with demand_busy=1 -> req_full=1 after 4 pushes, 5th dropped; release demand_busy -> 4 reads in FIFO order, none for the 5th.
- Fill 5 lines with LINES=4 -> first line evicted (lookup miss), lines 2-5 hit.
- rst_n low mid-ISSUE, then mem_resp pulse -> no buffer write, mem_read=0, all lookups miss.
- Consume entry during WRITE to the same victim slot -> entry valid with new line afterwards.

Source files
------------

// File: rtl/prefetch_buffer_if.sv
// Signal bundle linking the prefetch buffer to the prediction table, the L2 read port
// and the data-cache miss path. The master modport is the prefetch buffer's own view.
interface prefetch_buffer_if;
    logic [31:0]  pf_addr;
    logic         pf_en;
    logic         demand_busy;
    logic         mem_read;
    logic [31:0]  mem_addr;
    logic [255:0] mem_rdata;
    logic         mem_resp;
    logic [31:0]  lookup_addr;
    logic         lookup_valid;
    logic         lookup_hit;
    logic [255:0] lookup_data;
    logic         req_full;

    modport master (
        input  pf_addr, pf_en, demand_busy, mem_rdata, mem_resp, lookup_addr, lookup_valid,
        output mem_read, mem_addr, lookup_hit, lookup_data, req_full
    );

    modport slave (
        output pf_addr, pf_en, demand_busy, mem_rdata, mem_resp, lookup_addr, lookup_valid,
        input  mem_read, mem_addr, lookup_hit, lookup_data, req_full
    );
endinterface

// File: rtl/prefetch_buffer.sv
// Stride-prefetch consumer: queues de-duplicated prefetch lines, fetches them over L2
// when demand misses leave the port free, and holds returned lines for cache probes.
module prefetch_buffer #(
    parameter int DEPTH = 4,
    parameter int LINES = 4
) (
    input logic              clk,
    input logic              rst_n,
    prefetch_buffer_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(LINES);

    typedef enum logic [1:0] {IDLE, ISSUE, WRITE} state_t;

    state_t           state;
    state_t           state_next;
    logic [26:0]      fifo_line [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW:0]      count;
    logic [26:0]      buf_tag [LINES];
    logic [255:0]     buf_data [LINES];
    logic [LINES-1:0] buf_valid;
    logic [LW-1:0]    victim;
    logic [255:0]     resp_data;

    logic [26:0]      pf_line;
    logic [26:0]      lookup_line;
    logic             full;
    logic             in_fifo;
    logic             in_buf;
    logic             push;
    logic             pop;
    logic             hit;
    logic [LW-1:0]    hit_idx;
    logic [255:0]     hit_data;
    logic             unused_bits;

    assign pf_line     = bus.pf_addr[31:5];
    assign lookup_line = bus.lookup_addr[31:5];
    assign unused_bits = ^{bus.pf_addr[4:0], bus.lookup_addr[4:0]};
    assign full        = (count == (PW+1)'(DEPTH));

    // An entry is live when its distance from head is below the occupancy count.
    always_comb begin
        in_fifo = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, PW'(i) - head} < count) && (fifo_line[i] == pf_line)) begin
                in_fifo = 1'b1;
            end
        end
        in_buf = 1'b0;
        for (int i = 0; i < LINES; i++) begin
            if (buf_valid[i] && (buf_tag[i] == pf_line)) begin
                in_buf = 1'b1;
            end
        end
    end

    assign push = bus.pf_en && !full && !in_fifo && !in_buf;

    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_data = '0;
        for (int i = 0; i < LINES; i++) begin
            if (!hit && buf_valid[i] && (buf_tag[i] == lookup_line)) begin
                hit      = 1'b1;
                hit_idx  = LW'(i);
                hit_data = buf_data[i];
            end
        end
    end

    assign bus.lookup_hit  = hit;
    assign bus.lookup_data = hit_data;
    assign bus.req_full    = full;
    assign bus.mem_read    = (state == ISSUE);
    assign bus.mem_addr    = (state == ISSUE) ? {fifo_line[head], 5'b0} : 32'd0;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        unique case (state)
            IDLE:    if ((count != '0) && !bus.demand_busy) state_next = ISSUE;
            ISSUE:   if (bus.mem_resp) state_next = WRITE;
            WRITE: begin
                pop        = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Write is ordered after consume so a fill into the slot being consumed leaves it valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            buf_valid <= '0;
            victim    <= '0;
        end else begin
            state <= state_next;
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
            if (bus.lookup_valid && hit) buf_valid[hit_idx] <= 1'b0;
            if (state == WRITE) begin
                buf_valid[victim] <= 1'b1;
                victim            <= victim + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_line[tail] <= pf_line;
        if ((state == ISSUE) && bus.mem_resp) resp_data <= bus.mem_rdata;
        if (state == WRITE) begin
            buf_tag[victim]  <= fifo_line[head];
            buf_data[victim] <= resp_data;
        end
    end
endmodule

// File: tb/tb_prefetch_buffer.sv
// Directed bench for prefetch_buffer: issue timing, de-duplication, full FIFO,
// round-robin eviction, reset during a read and fill-versus-consume ordering.
module tb_prefetch_buffer;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   read_count;
    int   reads_before;

    prefetch_buffer_if bus();

    prefetch_buffer #(.DEPTH(4), .LINES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && bus.mem_read && bus.mem_resp) read_count++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [255:0] make_data(input int k);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(k * 32'h0101);
        return {w, ~w, w ^ 32'h5555_5555, w + 32'd7, w, ~w, w ^ 32'hAAAA_AAAA, w - 32'd3};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic en, input logic [31:0] addr);
        bus.pf_en   = en;
        bus.pf_addr = addr;
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        bus.pf_en        = 1'b0;
        bus.pf_addr      = '0;
        bus.demand_busy  = 1'b0;
        bus.mem_rdata    = '0;
        bus.mem_resp     = 1'b0;
        bus.lookup_addr  = '0;
        bus.lookup_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push_one(input logic [31:0] addr);
        apply_stimulus(1'b1, addr);
        tick();
        apply_stimulus(1'b0, 32'd0);
    endtask

    // Waits (bounded) for a read, checks its address, answers it; returns in the WRITE cycle.
    task automatic serve_read(input logic [31:0] exp_addr, input logic [255:0] data, input string tag);
        for (int i = 0; i < 12 && !bus.mem_read; i++) tick();
        check_output({tag, "_read"}, 256'(bus.mem_read), 256'(1));
        check_output({tag, "_addr"}, 256'(bus.mem_addr), 256'(exp_addr));
        bus.mem_rdata = data;
        bus.mem_resp  = 1'b1;
        tick();
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic fetch_line(input logic [31:0] exp_addr, input logic [255:0] data, input string tag);
        serve_read(exp_addr, data, tag);
        tick();
    endtask

    task automatic expect_no_read(input int cycles, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.mem_read) seen = 1'b1;
        end
        check_output(tag, 256'(seen), 256'(0));
    endtask

    task automatic probe(input logic [31:0] addr, input logic exp_hit, input logic [255:0] exp_data,
                         input string tag);
        bus.lookup_addr = addr;
        #1;
        check_output({tag, "_hit"}, 256'(bus.lookup_hit), 256'(exp_hit));
        check_output({tag, "_data"}, bus.lookup_data, exp_data);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        read_count = 0;

        // Reset values
        do_reset();
        check_output("rst_mem_read", 256'(bus.mem_read), 256'(0));
        check_output("rst_mem_addr", 256'(bus.mem_addr), 256'(0));
        check_output("rst_req_full", 256'(bus.req_full), 256'(0));
        probe(32'h0000_0000, 1'b0, 256'd0, "rst_lookup");

        // Single prefetch: issue timing, no bypass during WRITE, hit, consume
        push_one(32'h1000_0044);
        check_output("s1_idle_after_push", 256'(bus.mem_read), 256'(0));
        tick();
        check_output("s1_read_next_cycle", 256'(bus.mem_read), 256'(1));
        serve_read(32'h1000_0040, make_data(1), "s1");
        check_output("s1_read_low_in_write", 256'(bus.mem_read), 256'(0));
        probe(32'h1000_0050, 1'b0, 256'd0, "s1_no_bypass");
        tick();
        probe(32'h1000_0050, 1'b1, make_data(1), "s1_hit");
        bus.lookup_valid = 1'b1;
        tick();
        bus.lookup_valid = 1'b0;
        probe(32'h1000_0050, 1'b0, 256'd0, "s1_consumed");

        // Duplicate line while the first copy is queued and in flight
        do_reset();
        reads_before = read_count;
        push_one(32'h0000_0200);
        apply_stimulus(1'b1, 32'h0000_021C);
        tick();
        tick();
        apply_stimulus(1'b0, 32'd0);
        fetch_line(32'h0000_0200, make_data(2), "s2");
        push_one(32'h0000_0208);
        expect_no_read(8, "s2_no_second_read");
        check_output("s2_read_count", 256'(read_count - reads_before), 256'(1));
        probe(32'h0000_0210, 1'b1, make_data(2), "s2_hit");

        // Five lines while demand owns the port: fifth dropped, four read in order
        do_reset();
        reads_before    = read_count;
        bus.demand_busy = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            apply_stimulus(1'b1, 32'(k) << 12);
            tick();
            if (k == 3) check_output("s3_not_full_at_3", 256'(bus.req_full), 256'(0));
            if (k == 4) check_output("s3_full_at_4", 256'(bus.req_full), 256'(1));
        end
        apply_stimulus(1'b0, 32'd0);
        check_output("s3_full_after_5", 256'(bus.req_full), 256'(1));
        check_output("s3_held_by_demand", 256'(bus.mem_read), 256'(0));
        bus.demand_busy = 1'b0;
        for (int k = 1; k <= 4; k++) fetch_line(32'(k) << 12, make_data(10 + k), $sformatf("s3_line%0d", k));
        check_output("s3_not_full_after", 256'(bus.req_full), 256'(0));
        expect_no_read(8, "s3_fifth_dropped");
        check_output("s3_read_count", 256'(read_count - reads_before), 256'(4));

        // Fifth line evicts the oldest (slot 0)
        push_one(32'h0000_5000);
        fetch_line(32'h0000_5000, make_data(15), "s4");
        probe(32'h0000_1000, 1'b0, 256'd0, "s4_evicted");
        for (int k = 2; k <= 5; k++) probe((32'(k) << 12) + 32'h1C, 1'b1, make_data(10 + k), $sformatf("s4_line%0d", k));

        // Consume of the victim slot in the same cycle as the fill: fill wins
        push_one(32'h0000_6000);
        serve_read(32'h0000_6000, make_data(16), "s6");
        probe(32'h0000_6000, 1'b0, 256'd0, "s6_no_bypass");
        probe(32'h0000_2000, 1'b1, make_data(12), "s6_victim_before");
        bus.lookup_valid = 1'b1;
        tick();
        bus.lookup_valid = 1'b0;
        probe(32'h0000_6000, 1'b1, make_data(16), "s6_new_line");
        probe(32'h0000_2000, 1'b0, 256'd0, "s6_old_gone");

        // Reset during ISSUE, then a stray response
        do_reset();
        reads_before = read_count;
        push_one(32'h0000_7000);
        tick();
        check_output("s5_in_issue", 256'(bus.mem_read), 256'(1));
        rst_n = 1'b0;
        #1;
        check_output("s5_async_read", 256'(bus.mem_read), 256'(0));
        check_output("s5_async_addr", 256'(bus.mem_addr), 256'(0));
        tick();
        rst_n = 1'b1;
        tick();
        bus.mem_rdata = make_data(17);
        bus.mem_resp  = 1'b1;
        tick();
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        expect_no_read(6, "s5_fifo_emptied");
        probe(32'h0000_7000, 1'b0, 256'd0, "s5_no_write");
        probe(32'h0000_6000, 1'b0, 256'd0, "s5_valid_cleared");
        check_output("s5_req_full", 256'(bus.req_full), 256'(0));
        check_output("s5_read_count", 256'(read_count - reads_before), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
